// File: rtl/bali_uart_pkg.sv
// bali_uart_pkg: shared state, error codes and frame constants for the UART loader
package bali_uart_pkg;
  typedef enum logic [1:0] {IDLE, LEN_LO, DATA, CSUM} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_CSUM = 2'd1, ERR_TIMEOUT = 2'd2, ERR_LEN = 2'd3} err_t;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: received-byte input, memory write port and status of the loader
interface uart_loader_if #(parameter int ADDR_WIDTH = 16);
  import bali_uart_pkg::*;
  logic rx_done;
  logic [7:0] rx_data;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic busy;
  logic load_done;
  logic load_err;
  err_t err_code;
  modport master (
    output rx_done, rx_data,
    input mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code
  );
  modport slave (
    input rx_done, rx_data,
    output mem_we, mem_addr, mem_wdata, busy, load_done, load_err, err_code
  );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: writes a length-prefixed, checksummed byte image from uart_rx into memory
module uart_loader
  import bali_uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  uart_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [7:0] len_hi, sum;
  logic [15:0] len, len_next;
  logic [ADDR_WIDTH:0] cnt;
  logic [TW-1:0] tcnt;
  logic last, expired, too_long;
  assign len_next = {len_hi, bus.rx_data};
  assign last = (32'(cnt) + 32'd1) == 32'(len);
  assign too_long = 32'(len_next) > (32'd1 << ADDR_WIDTH);
  assign expired = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);
  // rx_done is checked before expiry so a byte arriving on the last cycle still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_hi <= '0;
      len <= '0;
      sum <= '0;
      cnt <= '0;
      tcnt <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_err <= 1'b0;
      bus.err_code <= ERR_NONE;
    end else begin
      bus.mem_we <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_err <= 1'b0;
      tcnt <= (bus.rx_done || state == IDLE) ? '0 : tcnt + 1'b1;
      if (bus.rx_done) begin
        case (state)
          IDLE: begin
            len_hi <= bus.rx_data;
            bus.err_code <= ERR_NONE;
            bus.busy <= 1'b1;
            state <= LEN_LO;
          end
          LEN_LO: begin
            len <= len_next;
            sum <= '0;
            cnt <= '0;
            if (too_long) begin
              state <= IDLE;
              bus.busy <= 1'b0;
              bus.load_err <= 1'b1;
              bus.err_code <= ERR_LEN;
            end else state <= len_next == 16'd0 ? CSUM : DATA;
          end
          DATA: begin
            bus.mem_we <= 1'b1;
            bus.mem_addr <= cnt[ADDR_WIDTH-1:0];
            bus.mem_wdata <= bus.rx_data;
            sum <= sum + bus.rx_data;
            cnt <= cnt + 1'b1;
            if (last) state <= CSUM;
          end
          CSUM: begin
            state <= IDLE;
            bus.busy <= 1'b0;
            if (bus.rx_data == sum) bus.load_done <= 1'b1;
            else begin
              bus.load_err <= 1'b1;
              bus.err_code <= ERR_CSUM;
            end
          end
        endcase
      end else if (expired) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.load_err <= 1'b1;
        bus.err_code <= ERR_TIMEOUT;
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames with hand-computed writes, pulses and error codes
module tb_uart_loader;
  import bali_uart_pkg::*;
  localparam int AW = 4, TO = 20;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, overlap = 0, back2back = 0;
  int d0, e0, w0;
  logic prev_we = 1'b0;
  logic [AW-1:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] fr[$];
  uart_loader_if #(.ADDR_WIDTH(AW)) bus ();
  uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.load_done) done_cnt++;
    if (bus.load_err) err_cnt++;
    if (bus.load_done && bus.load_err) overlap++;
    if (bus.mem_we && prev_we) back2back++;
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    prev_we = bus.mem_we;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame();
    foreach (fr[i]) begin
      send(fr[i]);
      idle(2);
    end
    idle(2);
  endtask
  task automatic mark();
    d0 = done_cnt;
    e0 = err_cnt;
    w0 = wa.size();
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.load_done, 0);
    check({tag, "_err"}, bus.load_err, 0);
    check({tag, "_code"}, bus.err_code, ERR_NONE);
  endtask
  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    check_idle_outputs("reset");
    // nominal 00 03 11 22 33 66
    mark();
    send(8'h00);
    check("nom_busy_hdr", bus.busy, 1);
    idle(2); send(8'h03); idle(2);
    send(8'h11);
    check("nom_we", bus.mem_we, 1);
    check("nom_addr0", bus.mem_addr, 0);
    check("nom_wdata0", bus.mem_wdata, 8'h11);
    idle(1);
    check("nom_we_drop", bus.mem_we, 0);
    idle(1); send(8'h22); idle(2); send(8'h33); idle(2);
    send(8'h66);
    check("nom_done_pulse", bus.load_done, 1);
    check("nom_busy_end", bus.busy, 0);
    idle(3);
    check("nom_nwr", wa.size() - w0, 6 - HDR_BYTES - 1);
    check("nom_w1", {wa[w0+1], wd[w0+1]}, {4'd1, 8'h22});
    check("nom_w2", {wa[w0+2], wd[w0+2]}, {4'd2, 8'h33});
    check("nom_done", done_cnt - d0, 1);
    check("nom_err", err_cnt - e0, 0);
    check("nom_code", bus.err_code, ERR_NONE);
    // bad checksum 00 02 AA 55 00 (correct sum is FF)
    mark();
    fr = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_frame();
    check("bad_nwr", wa.size() - w0, 2);
    check("bad_w0", {wa[w0], wd[w0]}, {4'd0, 8'hAA});
    check("bad_w1", {wa[w0+1], wd[w0+1]}, {4'd1, 8'h55});
    check("bad_err", err_cnt - e0, 1);
    check("bad_done", done_cnt - d0, 0);
    check("bad_code", bus.err_code, ERR_CSUM);
    // zero length, good then bad checksum
    mark();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame();
    check("zero_nwr", wa.size() - w0, 0);
    check("zero_done", done_cnt - d0, 1);
    check("zero_code", bus.err_code, ERR_NONE);
    mark();
    fr = '{8'h00, 8'h00, 8'h01};
    send_frame();
    check("zero_bad_err", err_cnt - e0, 1);
    check("zero_bad_code", bus.err_code, ERR_CSUM);
    // timeout: 00 05 01 then silence
    mark();
    send(8'h00);
    check("to_code_clear", bus.err_code, ERR_NONE);
    idle(2); send(8'h05); idle(2); send(8'h01);
    idle(TO - 1);
    check("to_early_err", bus.load_err, 0);
    check("to_early_busy", bus.busy, 1);
    idle(1);
    check("to_err_pulse", bus.load_err, 1);
    check("to_code", bus.err_code, ERR_TIMEOUT);
    check("to_busy", bus.busy, 0);
    idle(3);
    check("to_err_once", err_cnt - e0, 1);
    mark();
    fr = '{8'h00, 8'h01, 8'h7F, 8'h7F};
    send_frame();
    check("to_next_w", {wa[w0], wd[w0]}, {4'd0, 8'h7F});
    check("to_next_done", done_cnt - d0, 1);
    check("to_next_code", bus.err_code, ERR_NONE);
    // length overflow then maximum length (16 bytes 01..10, sum 0x88)
    mark();
    fr = '{8'h00, 8'h11};
    send_frame();
    check("ovf_err", err_cnt - e0, 1);
    check("ovf_code", bus.err_code, ERR_LEN);
    check("ovf_nwr", wa.size() - w0, 0);
    check("ovf_busy", bus.busy, 0);
    mark();
    fr = '{8'h00, 8'h10};
    for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h88);
    send_frame();
    check("max_nwr", wa.size() - w0, 16);
    for (int i = 0; i < 16; i++) check($sformatf("max_w%0d", i), {wa[w0+i], wd[w0+i]}, {4'(i), 8'(i + 1)});
    check("max_done", done_cnt - d0, 1);
    check("max_err", err_cnt - e0, 0);
    // reset after second data byte of a 4-byte frame
    mark();
    send(8'h00); idle(2); send(8'h04); idle(2); send(8'hA1); idle(2);
    send(8'hA2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    idle(TO + 5);
    check("rst_mid_err", err_cnt - e0, 0);
    check("rst_mid_done", done_cnt - d0, 0);
    mark();
    fr = '{8'h00, 8'h01, 8'h5A, 8'h5A};
    send_frame();
    check("rst_next_w", {wa[w0], wd[w0]}, {4'd0, 8'h5A});
    check("rst_next_done", done_cnt - d0, 1);
    check("overlap", overlap, 0);
    check("back2back_we", back2back, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
